audio_channel_mixer: RTL and testbench

Parametrised, time-multiplexed N-channel PCM mixer for the APU: once per output-sample period it latches every voice sample, applies its per-channel Q1.15 gain through a single shared multiplier, sums, applies a click-free ramped master gain, saturates and emits one PCM word with a valid pulse. It sits between the synthesis voices and the PCM-to-PDM output stage, replacing the fixed 4-voice mixing path with configurable channel count, sample width and sample rate, plus soft mute and clip reporting.

---
 rtl/audio_channel_mixer.sv | 185 ++++++++++++++++++
 tb/tb_audio_channel_mixer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/audio_channel_mixer.sv
// Time-multiplexed N-channel PCM mixer: per-channel Q1.x gain through one shared
// multiplier, ramped master gain, saturation with sticky clip reporting.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for the sample-rate tick
// ST_LATCH  | snapshot voices/gains/enables, clear acc, step master gain
// ST_ACCUM  | one channel per cycle: acc += (sample*gain) >>> (GW-1)
// ST_MASTER | acc*g through the shared multiplier, saturate, register out
// ST_OUTPUT | output valid for one cycle, clip flag update
module audio_channel_mixer #(
   parameter int CHANNELS     = 4,
   parameter int SAMPLE_WIDTH = 16,
   parameter int GAIN_WIDTH   = 16,
   parameter int SAMPLE_DIV   = 2083,
   parameter int RAMP_STEP    = 256
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             enable_i,
   input  logic [CHANNELS-1:0]              channel_enable_i,
   input  logic [CHANNELS*SAMPLE_WIDTH-1:0] channel_sample_i,
   input  logic [CHANNELS*GAIN_WIDTH-1:0]   channel_gain_i,
   input  logic [GAIN_WIDTH-1:0]            master_gain_i,
   input  logic                             mute_i,
   input  logic                             clip_clear_i,
   output logic [SAMPLE_WIDTH-1:0]          mixed_sample_o,
   output logic                             sample_valid_o,
   output logic                             clip_o,
   output logic                             busy_o
);

   localparam int ACC_W  = SAMPLE_WIDTH + $clog2(CHANNELS) + 1;
   localparam int PROD_W = ACC_W + GAIN_WIDTH;
   localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int CNT_W  = $clog2(SAMPLE_DIV);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHANNELS - 1);
   localparam logic signed [GAIN_WIDTH+1:0] STEP = (GAIN_WIDTH+2)'(RAMP_STEP);
   localparam logic signed [PROD_W-1:0] SAT_MAX =
      {{(PROD_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
   localparam logic signed [PROD_W-1:0] SAT_MIN =
      {{(PROD_W-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE, ST_LATCH, ST_ACCUM, ST_MASTER, ST_OUTPUT
   } state_t;

   state_t state, state_nxt;

   logic [CNT_W-1:0]              cnt;
   logic                          tick;
   logic [IDX_W-1:0]              idx;
   logic signed [ACC_W-1:0]       acc;
   logic signed [GAIN_WIDTH-1:0]  g_q;
   logic signed [GAIN_WIDTH-1:0]  target;
   logic signed [GAIN_WIDTH-1:0]  g_nxt;
   logic signed [GAIN_WIDTH+1:0]  diff;
   logic signed [GAIN_WIDTH+1:0]  step_c;
   logic signed [GAIN_WIDTH+1:0]  g_sum;
   logic signed [SAMPLE_WIDTH-1:0] smp_q  [CHANNELS];
   logic signed [GAIN_WIDTH-1:0]   gain_q [CHANNELS];
   logic [CHANNELS-1:0]           en_q;
   logic                          sat_q;

   logic signed [ACC_W-1:0]       op_a;
   logic signed [GAIN_WIDTH-1:0]  op_b;
   logic signed [PROD_W-1:0]      prod;
   logic signed [PROD_W-1:0]      prod_sh;
   logic signed [ACC_W-1:0]       term;
   logic                          sat_hi;
   logic                          sat_lo;
   logic [SAMPLE_WIDTH-1:0]       sat_val;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt <= '0;
      end else if (!enable_i || cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tick = enable_i && (cnt == CNT_LAST);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (tick) state_nxt = ST_LATCH;
         ST_LATCH:  state_nxt = ST_ACCUM;
         ST_ACCUM:  if (idx == IDX_LAST) state_nxt = ST_MASTER;
         ST_MASTER: state_nxt = ST_OUTPUT;
         ST_OUTPUT: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   assign busy_o = (state != ST_IDLE);

   // Master gain moves toward its target by at most STEP per output sample.
   assign target = mute_i ? '0 : $signed(master_gain_i);

   always_comb begin
      diff = {{2{target[GAIN_WIDTH-1]}}, target} - {{2{g_q[GAIN_WIDTH-1]}}, g_q};
      if (RAMP_STEP == 0)      step_c = diff;
      else if (diff > STEP)    step_c = STEP;
      else if (diff < -STEP)   step_c = -STEP;
      else                     step_c = diff;
      g_sum = {{2{g_q[GAIN_WIDTH-1]}}, g_q} + step_c;
      g_nxt = g_sum[GAIN_WIDTH-1:0];
   end

   // One multiplier serves both the channel gains and the master gain.
   always_comb begin
      op_a = acc;
      op_b = g_q;
      if (state == ST_ACCUM) begin
         op_a = {{(ACC_W-SAMPLE_WIDTH){smp_q[idx][SAMPLE_WIDTH-1]}}, smp_q[idx]};
         op_b = gain_q[idx];
      end
      prod    = PROD_W'(op_a) * PROD_W'(op_b);
      prod_sh = prod >>> (GAIN_WIDTH - 1);
      term    = en_q[idx] ? prod_sh[ACC_W-1:0] : '0;
      sat_hi  = (prod_sh > SAT_MAX);
      sat_lo  = (prod_sh < SAT_MIN);
      if (sat_hi)      sat_val = SAT_MAX[SAMPLE_WIDTH-1:0];
      else if (sat_lo) sat_val = SAT_MIN[SAMPLE_WIDTH-1:0];
      else             sat_val = prod_sh[SAMPLE_WIDTH-1:0];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc            <= '0;
         idx            <= '0;
         g_q            <= '0;
         en_q           <= '0;
         sat_q          <= 1'b0;
         mixed_sample_o <= '0;
         sample_valid_o <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            smp_q[i]  <= '0;
            gain_q[i] <= '0;
         end
      end else begin
         sample_valid_o <= 1'b0;
         case (state)
            ST_LATCH: begin
               for (int i = 0; i < CHANNELS; i++) begin
                  smp_q[i]  <= channel_sample_i[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                  gain_q[i] <= channel_gain_i[i*GAIN_WIDTH +: GAIN_WIDTH];
               end
               en_q <= channel_enable_i;
               acc  <= '0;
               idx  <= '0;
               g_q  <= g_nxt;
            end
            ST_ACCUM: begin
               acc <= acc + term;
               idx <= idx + IDX_W'(1);
            end
            ST_MASTER: begin
               mixed_sample_o <= sat_val;
               sample_valid_o <= 1'b1;
               sat_q          <= sat_hi | sat_lo;
            end
            default: ;
         endcase
      end
   end

   // A saturation in the output cycle beats a simultaneous clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                              clip_o <= 1'b0;
      else if (state == ST_OUTPUT && sat_q)   clip_o <= 1'b1;
      else if (clip_clear_i)                  clip_o <= 1'b0;
   end

endmodule

// File: tb/tb_audio_channel_mixer.sv
// Directed bench for audio_channel_mixer: two instances (no ramp / ramped master
// gain) with 4 channels and a 16-clock sample period.
module tb_audio_channel_mixer;

   logic        clk = 1'b0;
   logic        rst0, rst1, en, mute, clr;
   logic [3:0]  chen;
   logic [63:0] samp, gain;
   logic [15:0] mgain;
   logic [15:0] out0, out1;
   logic        val0, val1, clip0, clip1, busy0, busy1;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   audio_channel_mixer #(.CHANNELS(4), .SAMPLE_WIDTH(16), .GAIN_WIDTH(16),
                         .SAMPLE_DIV(16), .RAMP_STEP(0)) dut0 (
      .clk_i(clk), .rst_i(rst0), .enable_i(en), .channel_enable_i(chen),
      .channel_sample_i(samp), .channel_gain_i(gain), .master_gain_i(mgain),
      .mute_i(mute), .clip_clear_i(clr), .mixed_sample_o(out0),
      .sample_valid_o(val0), .clip_o(clip0), .busy_o(busy0));

   audio_channel_mixer #(.CHANNELS(4), .SAMPLE_WIDTH(16), .GAIN_WIDTH(16),
                         .SAMPLE_DIV(16), .RAMP_STEP(8192)) dut1 (
      .clk_i(clk), .rst_i(rst1), .enable_i(en), .channel_enable_i(chen),
      .channel_sample_i(samp), .channel_gain_i(gain), .master_gain_i(mgain),
      .mute_i(mute), .clip_clear_i(clr), .mixed_sample_o(out1),
      .sample_valid_o(val1), .clip_o(clip1), .busy_o(busy1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_chan(input logic [15:0] s, input logic [3:0] mask);
      samp = {4{s}};
      gain = {4{16'h7FFF}};
      chen = mask;
   endtask

   task automatic wait_valid(input int which, input int budget, output int cycles);
      cycles = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         cycles++;
         if ((which == 0) ? val0 : val1) return;
      end
      chk("valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_busy(input int which, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if ((which == 0) ? busy0 : busy1) return;
      end
      chk("busy_timeout", 32'd0, 32'd1);
   endtask

   logic [15:0] ramp_exp [8] = '{16'h0FFF, 16'h1FFF, 16'h2FFF, 16'h3FFE,
                                 16'h2FFE, 16'h1FFF, 16'h0FFF, 16'h0000};

   initial begin
      int          cyc;
      int          n;
      logic        saw;
      logic [15:0] got;

      rst0 = 1'b1; rst1 = 1'b1; en = 1'b0; mute = 1'b0; clr = 1'b0;
      mgain = 16'h7FFF;
      set_chan(16'h4000, 4'b0001);
      repeat (3) @(negedge clk);

      chk("rst_out0", 32'(out0), 0);   chk("rst_val0", 32'(val0), 0);
      chk("rst_clip0", 32'(clip0), 0); chk("rst_busy0", 32'(busy0), 0);
      chk("rst_out1", 32'(out1), 0);   chk("rst_busy1", 32'(busy1), 0);

      // first tick on the 16th enabled cycle, output 7 cycles later
      rst0 = 1'b0;
      @(negedge clk);
      en = 1'b1;
      wait_valid(0, 40, cyc);
      chk("first_latency", 32'(cyc + 1), 23);
      chk("single_ch", 32'(out0), 32'h3FFE);
      @(negedge clk);
      chk("valid_pulse", 32'(val0), 0);
      chk("idle_after_out", 32'(busy0), 0);
      wait_valid(0, 20, cyc);
      chk("period", 32'(cyc + 1), 16);
      chk("single_ch_again", 32'(out0), 32'h3FFE);
      @(negedge clk);
      chk("no_clip_single", 32'(clip0), 0);

      // saturation both ways
      set_chan(16'h7000, 4'b1111);
      wait_valid(0, 20, cyc);
      chk("sat_pos", 32'(out0), 32'h7FFF);
      set_chan(16'h9000, 4'b1111);
      @(negedge clk);
      chk("clip_set", 32'(clip0), 1);
      wait_valid(0, 20, cyc);
      chk("sat_neg", 32'(out0), 32'h8000);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clip_set_wins", 32'(clip0), 1);

      // reset in the middle of a mix
      wait_busy(0, 20);
      @(negedge clk);
      rst0 = 1'b1;
      en = 1'b0;
      #1;
      chk("midrst_out", 32'(out0), 0);   chk("midrst_val", 32'(val0), 0);
      chk("midrst_clip", 32'(clip0), 0); chk("midrst_busy", 32'(busy0), 0);
      saw = 1'b0;
      repeat (10) begin
         @(negedge clk);
         saw = saw | val0;
      end
      chk("no_valid_in_reset", 32'(saw), 0);
      rst0 = 1'b0;
      en = 1'b1;
      wait_valid(0, 40, cyc);
      chk("latency_after_rst", 32'(cyc + 1), 23);
      chk("sat_neg_after_rst", 32'(out0), 32'h8000);

      // clear on a non-saturating sample
      set_chan(16'h4000, 4'b0001);
      @(negedge clk);
      chk("clip_before_clear", 32'(clip0), 1);
      wait_valid(0, 20, cyc);
      chk("unsat_sample", 32'(out0), 32'h3FFE);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clip_cleared", 32'(clip0), 0);

      // inputs changed during ACCUM only affect the next sample
      wait_busy(0, 20);
      @(negedge clk);
      samp[15:0] = 16'h2000;
      wait_valid(0, 20, cyc);
      chk("snapshot_cur", 32'(out0), 32'h3FFE);
      wait_busy(0, 20);
      n = 0;
      got = 16'h0;
      for (int i = 0; i < 20; i++) begin
         if (!busy0) break;
         n++;
         if (val0) got = out0;
         @(negedge clk);
      end
      chk("busy_len", 32'(n), 7);
      chk("snapshot_next", 32'(got), 32'h1FFE);

      // ramped master gain, then mute
      set_chan(16'h4000, 4'b0001);
      mute = 1'b0;
      @(negedge clk);
      rst1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wait_valid(1, 40, cyc);
         chk($sformatf("ramp_%0d", i), 32'(out1), 32'(ramp_exp[i]));
         if (i == 3) mute = 1'b1;
      end
      chk("ramp_no_clip", 32'(clip1), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
